// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operation sequencer: ALU/ARM opcodes,
// NZCV bit positions and the sequencer state encoding.
package alu_pkg;

    localparam logic [4:0] ALU_AND    = 5'b00000;
    localparam logic [4:0] ALU_EOR    = 5'b00001;
    localparam logic [4:0] ALU_SUB    = 5'b00010;
    localparam logic [4:0] ALU_RSB    = 5'b00011;
    localparam logic [4:0] ALU_ADD    = 5'b00100;
    localparam logic [4:0] ALU_ADC    = 5'b00101;
    localparam logic [4:0] ALU_SBC    = 5'b00110;
    localparam logic [4:0] ALU_RSC    = 5'b00111;
    localparam logic [4:0] ALU_TST    = 5'b01000;
    localparam logic [4:0] ALU_TEQ    = 5'b01001;
    localparam logic [4:0] ALU_CMP    = 5'b01010;
    localparam logic [4:0] ALU_CMN    = 5'b01011;
    localparam logic [4:0] ALU_ORR    = 5'b01100;
    localparam logic [4:0] ALU_MOV    = 5'b01101;
    localparam logic [4:0] ALU_BIC    = 5'b01110;
    localparam logic [4:0] ALU_MVN    = 5'b01111;
    localparam logic [4:0] ALU_BYPASS = 5'b10000;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StExec,
        StWb
    } seq_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of an ARM data-processing opcode into the ALU opcode plus
// the test-op and no-first-operand qualifiers.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic [4:0] alu_op_o,
    output logic       is_test_o,
    output logic       no_rn_o
);

    always_comb begin
        alu_op_o = {1'b0, opcode_i};
        // MOV is executed as a pass-through of operand B.
        if (opcode_i == OP_MOV) begin
            alu_op_o = ALU_BYPASS;
        end
    end

    assign is_test_o = (opcode_i[3:2] == 2'b10);
    assign no_rn_o   = (opcode_i == OP_MOV) || (opcode_i == OP_MVN);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller: reads operands from a single-port register file, runs one
// data-processing op through the shared ALU, writes back and owns the NZCV register.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned RF_AW = 4,
    parameter int unsigned DW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic             cmd_s,
    input  logic             cmd_imm,
    input  logic [RF_AW-1:0] cmd_rd,
    input  logic [RF_AW-1:0] cmd_rn,
    input  logic [RF_AW-1:0] cmd_rm,
    input  logic [DW-1:0]    cmd_imm32,
    output logic [RF_AW-1:0] rf_addr,
    input  logic [DW-1:0]    rf_rdata,
    output logic             rf_we,
    output logic [DW-1:0]    rf_wdata,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    output logic [4:0]       alu_op,
    output logic             alu_s,
    output logic             alu_out_en,
    input  logic [DW-1:0]    alu_result,
    output logic [3:0]       alu_flags_in,
    input  logic [3:0]       alu_flags,
    output logic [3:0]       flags,
    output logic             done
);

    logic [4:0] dec_op;
    logic       dec_is_test;
    logic       dec_no_rn;

    alu_op_decode u_decode (
        .opcode_i  (cmd_opcode),
        .alu_op_o  (dec_op),
        .is_test_o (dec_is_test),
        .no_rn_o   (dec_no_rn)
    );

    seq_state_e       state_q, state_d;
    logic [RF_AW-1:0] rd_q, rm_q;
    logic             imm_q, is_test_q;
    logic             eff_s_q, eff_s_d;
    logic [4:0]       op_q, op_d;
    logic [DW-1:0]    a_q, a_d, b_q, b_d;
    logic [DW-1:0]    res_q;
    logic [3:0]       hflags_q, flags_q;
    logic [RF_AW-1:0] rf_addr_q, rf_addr_d;
    logic             rf_we_q, done_q;
    logic [DW-1:0]    alu_a_q, alu_b_q;
    logic [4:0]       alu_op_q;
    logic             alu_s_q, alu_out_en_q;
    logic             accept, enter_exec;

    assign cmd_ready  = (state_q == StIdle);
    assign accept     = cmd_valid && cmd_ready;
    assign enter_exec = (state_d == StExec) && (state_q != StExec);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        eff_s_d   = eff_s_q;
        rf_addr_d = rf_addr_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d     = '0;
                    b_d     = cmd_imm32;
                    op_d    = dec_op;
                    // Test ops always commit flags, whatever S says.
                    eff_s_d = cmd_s | dec_is_test;
                    if (!dec_no_rn) begin
                        rf_addr_d = cmd_rn;
                        state_d   = StRdA;
                    end else if (!cmd_imm) begin
                        rf_addr_d = cmd_rm;
                        state_d   = StRdB;
                    end else begin
                        state_d   = StExec;
                    end
                end
            end
            StRdA: begin
                a_d = rf_rdata;
                if (imm_q) begin
                    state_d = StExec;
                end else begin
                    rf_addr_d = rm_q;
                    state_d   = StRdB;
                end
            end
            StRdB: begin
                b_d     = rf_rdata;
                state_d = StExec;
            end
            StExec: begin
                rf_addr_d = rd_q;
                state_d   = StWb;
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rd_q         <= '0;
            rm_q         <= '0;
            imm_q        <= 1'b0;
            is_test_q    <= 1'b0;
            eff_s_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            hflags_q     <= '0;
            flags_q      <= '0;
            rf_addr_q    <= '0;
            rf_we_q      <= 1'b0;
            done_q       <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_s_q      <= 1'b0;
            alu_out_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            eff_s_q   <= eff_s_d;
            rf_addr_q <= rf_addr_d;
            if (accept) begin
                rd_q      <= cmd_rd;
                rm_q      <= cmd_rm;
                imm_q     <= cmd_imm;
                is_test_q <= dec_is_test;
            end
            if (enter_exec) begin
                alu_a_q  <= a_d;
                alu_b_q  <= b_d;
                alu_op_q <= op_d;
                alu_s_q  <= eff_s_d;
            end
            alu_out_en_q <= (state_d == StExec);
            if (state_q == StExec) begin
                res_q    <= alu_result;
                hflags_q <= alu_flags;
            end
            rf_we_q <= (state_d == StWb) && !is_test_q;
            done_q  <= (state_d == StWb);
            if ((state_q == StWb) && eff_s_q) begin
                flags_q <= hflags_q;
            end
        end
    end

    assign rf_addr      = rf_addr_q;
    assign rf_we        = rf_we_q;
    assign rf_wdata     = res_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign alu_s        = alu_s_q;
    assign alu_out_en   = alu_out_en_q;
    assign alu_flags_in = flags_q;
    assign flags        = flags_q;
    assign done         = done_q;

endmodule
